gray_code_counter: RTL and testbench
====================================

Name: gray_code_counter

Overview:
Synchronous up/down counter that emits its count as registered Gray code. It is the upstream source stage for the Gray-to-binary decoder: o_gray connects directly to the decoder's 4-bit Gray input. Typical uses are position/pointer generation where only one output bit may change per step. Supports enable, direction, synchronous binary load, and wrap or saturate at the range limits.

Parameters:
WIDTH, 4, count width in bits (>=2); also the width of o_gray and i_load_bin
WRAP, 1, 1 = modular wrap at limits; 0 = saturate (hold) at limits

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, synchronous, active-high
i_en  input  1  step enable; one step per cycle while high
i_up  input  1  direction: 1 = increment, 0 = decrement; sampled only when i_en=1
i_load  input  1  synchronous load strobe
i_load_bin  input  WIDTH  binary value to load; sampled when i_load=1
o_gray  output  WIDTH  current count, Gray-encoded, registered
o_step  output  1  registered pulse: count changed on the previous edge
o_wrap  output  1  registered pulse: previous step wrapped (max->0 up, 0->max down)
o_at_limit  output  1  level: count == max when i_up=1, or count == 0 when i_up=0 (combinational from state and i_up)

Behaviour:
- Reset: one clock only, synchronous, active-high (i_clk, i_rst). At the edge with i_rst=1: internal binary count=0, o_gray=0, o_step=0, o_wrap=0. i_rst overrides i_load and i_en.
- State: internal binary register cnt[WIDTH-1:0]. o_gray is a register loaded with gray(next_cnt), where gray(b) = b ^ (b>>1). At every edge o_gray equals gray(cnt). There are no extra pipeline stages.
- Priority per edge: i_rst > i_load > i_en > hold.
- Load: cnt <= i_load_bin and o_gray <= gray(i_load_bin), visible on the cycle after the strobe. o_step=1 only if the loaded value differs from cnt. o_wrap=0. i_en is ignored on a load cycle.
- Step, i_en=1 and not at a limit: cnt <= cnt±1. o_step=1, o_wrap=0.
- Step at a limit (up at max = 2^WIDTH-1, or down at 0):
  - WRAP=1: cnt wraps modulo 2^WIDTH. o_step=1, o_wrap=1 for exactly one cycle.
  - WRAP=0: cnt holds. o_step=0, o_wrap=0.
- Hold, i_en=0 and i_load=0: cnt unchanged. o_step=0, o_wrap=0.
- Invariant: every step (not load) changes exactly one bit of o_gray, including at the wrap.
- Direction may change on any cycle with no penalty. Consecutive steps are allowed every cycle.
- Reset mid-count, with i_en high: the next edge gives o_gray=0. Counting resumes on the following enabled edge (0 -> gray 1 when up).
- o_at_limit is the only combinational output. It depends only on cnt and i_up, never on i_en or i_load.

Decomposition:
- Shared package gray_pkg holds:
  - function bin2gray(WIDTH-generic via parameterised width)
  - function gray2bin, for bench use
  - localparam for the default width 4
- No sub-module. The encoder is a one-line function, and the counter is a single always block plus a flag register block.

Test Plan:
- Reset then hold: i_rst=1 for 2 cycles, then i_en=0 -> o_gray=0, o_step=0, o_wrap=0. o_at_limit=1 with i_up=0.
- Full up sweep, WIDTH=4, WRAP=1, i_en=1, i_up=1 for 16 cycles:
  - o_gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - o_wrap pulses once, on the cycle after 8->0.
  - Each transition has Hamming distance 1 and o_step=1.
- Down wrap: from reset, i_up=0, i_en=1 for one cycle -> o_gray=8 (binary 15), o_wrap=1. Next step gives o_gray=9 (binary 14), o_wrap=0.
- Load priority: i_load_bin=5 with i_load=1 and i_en=1 -> o_gray=7 next cycle, o_step=1, no increment. Reloading 5 -> o_step=0.
- Saturate, WRAP=0: load 15, then i_up=1, i_en=1 for 3 cycles -> o_gray stays 8, o_at_limit=1, o_step=0, o_wrap=0. Switch i_up=0 -> o_gray=9.
- Reset mid-operation: counting up at o_gray=C, assert i_rst with i_en=1 and i_load=1 -> next edge o_gray=0, o_wrap=0. Release -> o_gray=1.
- Chain check: connect o_gray to the Gray-to-binary decoder. Over a random en/up/load sequence, decoded binary equals the model count, delayed by one cycle.

Source files
------------

// File: rtl/gray_code_counter_pkg.sv
// Shared Gray-code helpers for the counter and anything that consumes its output.
// Functions work on GRAY_MAX_W bits; callers size-cast to their own width.
package gray_pkg;

   localparam int GRAY_DEFAULT_W = 4;
   localparam int GRAY_MAX_W     = 32;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at and above it.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = '0;
      for (int i = 0; i < GRAY_MAX_W; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_code_counter.sv
// Up/down binary counter with load and wrap/saturate, presenting its count as registered Gray code.
// Flags o_step/o_wrap describe the edge that produced the current o_gray.
module gray_code_counter
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_DEFAULT_W,
   parameter bit WRAP  = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_up,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_bin,
   output logic [WIDTH-1:0] o_gray,
   output logic             o_step,
   output logic             o_wrap,
   output logic             o_at_limit
);

   localparam logic [WIDTH-1:0] MAX_CNT = '1;

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;
   logic             at_max, at_zero;

   assign at_max  = (cnt_q == MAX_CNT);
   assign at_zero = (cnt_q == '0);

   always_comb begin
      cnt_d  = cnt_q;
      step_d = 1'b0;
      wrap_d = 1'b0;
      if (i_load) begin
         cnt_d  = i_load_bin;
         step_d = (i_load_bin != cnt_q);
      end else if (i_en) begin
         if ((i_up && at_max) || (!i_up && at_zero)) begin
            // Modular +/-1 lands on the opposite limit; saturating mode just holds.
            if (WRAP) begin
               cnt_d  = i_up ? '0 : MAX_CNT;
               step_d = 1'b1;
               wrap_d = 1'b1;
            end
         end else begin
            cnt_d  = i_up ? cnt_q + 1'b1 : cnt_q - 1'b1;
            step_d = 1'b1;
         end
      end
      gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(cnt_d)));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q  <= '0;
         gray_q <= '0;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         gray_q <= gray_d;
         step_q <= step_d;
         wrap_q <= wrap_d;
      end
   end

   assign o_gray     = gray_q;
   assign o_step     = step_q;
   assign o_wrap     = wrap_q;
   assign o_at_limit = i_up ? at_max : at_zero;

endmodule

// File: tb/tb_gray_code_counter.sv
// Drives a wrapping and a saturating counter with identical stimulus; a reference model
// queues expected results per edge and a monitor compares them after each rising edge.
module tb_gray_code_counter;
   import gray_pkg::*;

   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   typedef struct {
      int gray;
      int cnt;
      bit step;
      bit wrap;
      bit lim;
      bit no_hamming;
   } exp_t;

   logic         clk = 1'b0;
   logic         i_rst = 1'b1, i_en = 1'b0, i_up = 1'b0, i_load = 1'b0;
   logic [W-1:0] i_load_bin = '0;
   logic [W-1:0] gray_w, gray_s;
   logic         step_w, step_s, wrap_w, wrap_s, lim_w, lim_s;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   m_cnt[2] = '{0, 0};
   int   prev_gray[2] = '{0, 0};
   int   n_wraps_w = 0;
   exp_t q_w[$];
   exp_t q_s[$];
   bit   done = 1'b0;

   always #5 clk = ~clk;

   gray_code_counter #(.WIDTH(W), .WRAP(1'b1)) dut_w (
      .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_up(i_up), .i_load(i_load),
      .i_load_bin(i_load_bin), .o_gray(gray_w), .o_step(step_w), .o_wrap(wrap_w),
      .o_at_limit(lim_w)
   );

   gray_code_counter #(.WIDTH(W), .WRAP(1'b0)) dut_s (
      .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_up(i_up), .i_load(i_load),
      .i_load_bin(i_load_bin), .o_gray(gray_s), .o_step(step_s), .o_wrap(wrap_s),
      .o_at_limit(lim_s)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: integer count, +/-1 with range test; m=0 wraps modulo 2^W, m=1 saturates.
   function automatic exp_t model(input int m, input bit rst, en, up, load, input int bin);
      exp_t e;
      int   old = m_cnt[m];
      int   nxt = old;
      e.step = 0;
      e.wrap = 0;
      e.no_hamming = rst || load;
      if (rst) begin
         nxt = 0;
      end else if (load) begin
         nxt    = bin;
         e.step = (bin != old);
      end else if (en) begin
         nxt = up ? old + 1 : old - 1;
         if (nxt < 0 || nxt > MAXV) begin
            if (m == 0) begin
               nxt    = (nxt + MAXV + 1) % (MAXV + 1);
               e.step = 1;
               e.wrap = 1;
            end else begin
               nxt = old;
            end
         end else begin
            e.step = 1;
         end
      end
      m_cnt[m] = nxt;
      e.cnt  = nxt;
      e.gray = nxt ^ (nxt >> 1);
      e.lim  = up ? (nxt == MAXV) : (nxt == 0);
      return e;
   endfunction

   task automatic drive(input bit rst, en, up, load, input int bin);
      i_rst      = rst;
      i_en       = en;
      i_up       = up;
      i_load     = load;
      i_load_bin = W'(bin);
      q_w.push_back(model(0, rst, en, up, load, bin));
      q_s.push_back(model(1, rst, en, up, load, bin));
      $display("drive rst=%0d en=%0d up=%0d load=%0d bin=%0d -> model wrap=%0d sat=%0d",
               rst, en, up, load, bin, m_cnt[0], m_cnt[1]);
      @(negedge clk);
   endtask

   task automatic check_dut(input int m, input string tag, input exp_t e,
                            input logic [W-1:0] g, input logic st, wr, lm);
      chk({tag, " o_gray"}, int'(g), e.gray);
      chk({tag, " o_step"}, int'(st), int'(e.step));
      chk({tag, " o_wrap"}, int'(wr), int'(e.wrap));
      chk({tag, " o_at_limit"}, int'(lm), int'(e.lim));
      chk({tag, " decoded"}, int'(gray2bin(GRAY_MAX_W'(g))), e.cnt);
      if (e.step && !e.no_hamming)
         chk({tag, " hamming"}, $countones(W'(prev_gray[m]) ^ g), 1);
      prev_gray[m] = int'(g);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q_w.size() != 0) begin
            e = q_w.pop_front();
            check_dut(0, "wrap", e, gray_w, step_w, wrap_w, lim_w);
            if (wrap_w) n_wraps_w++;
         end
         if (q_s.size() != 0) begin
            e = q_s.pop_front();
            check_dut(1, "sat", e, gray_s, step_s, wrap_s, lim_s);
         end
         if (done) break;
      end
   end

   initial begin : stimulus
      int w0;
      // Reset, then hold with i_up=0 (at_limit expected high at zero).
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      // Full up sweep: 16 steps back to 0, one wrap pulse on the wrapping counter.
      w0 = n_wraps_w;
      for (int i = 0; i < 16; i++) drive(0, 1, 1, 0, 0);
      drive(0, 0, 1, 0, 0);
      chk("sweep wrap pulses", n_wraps_w - w0, 1);
      // Down wrap from reset, then one more step down.
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0);
      drive(0, 1, 0, 0, 0);
      // Load priority over enable, then reload same value.
      drive(0, 1, 1, 1, 5);
      drive(0, 0, 1, 1, 5);
      // Load max then push up: saturate vs wrap; then reverse.
      drive(0, 0, 1, 1, 15);
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0);
      drive(0, 1, 0, 0, 0);
      // Reset mid-count at gray C with en and load asserted, then resume.
      drive(1, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++) drive(0, 1, 1, 0, 0);
      drive(1, 1, 1, 1, 9);
      drive(0, 1, 1, 0, 0);
      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(39) == 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
               $urandom_range(7) == 0, int'($urandom_range(MAXV)));
      end
      drive(0, 0, 0, 0, 0);
      done = 1'b1;
      repeat (3) @(negedge clk);
      chk("queues drained", q_w.size() + q_s.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
